// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Message-level round-robin arbiter sharing one UART TX byte port
//            among NREQ sources. A source holds the port for a whole message
//            (valid/ready/last handshake), and a silent holder is dropped
//            after IDLE_MAX cycles with a one-cycle ABORT pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DW       = 8,
    parameter int NREQ     = 4,
    parameter int IDLE_MAX = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    input  logic [NREQ-1:0]    REQ_LAST,
    output logic [NREQ-1:0]    REQ_READY,
    output logic [NREQ-1:0]    GNT,
    output logic               TX_WEN,
    output logic [DW-1:0]      TX_DIN,
    input  logic               TX_RDY,
    output logic               BUSY,
    output logic               ABORT
);

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW = $clog2(IDLE_MAX);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_XFER = 1'b1;

    logic [0:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [c_PW-1:0] r_ptr;
    logic [c_CW-1:0] r_scnt;
    logic            r_abort;

    logic [0:0]      w_state_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [c_PW-1:0] w_ptr_nxt;
    logic [c_CW-1:0] w_scnt_nxt;
    logic            w_abort_nxt;

    logic [c_PW-1:0] w_hold_idx;
    logic            w_valid_g;
    logic            w_last_g;
    logic [DW-1:0]   w_data_g;
    logic            w_xfer;
    logic [NREQ-1:0] w_pick;
    logic            w_found;
    int              w_idx;

    // Decode the one-hot grant into the holder's index and its lane signals
    always_comb begin
        w_hold_idx = '0;
        w_valid_g  = 1'b0;
        w_last_g   = 1'b0;
        w_data_g   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_hold_idx = c_PW'(i);
                w_valid_g  = REQ_VALID[i];
                w_last_g   = REQ_LAST[i];
                w_data_g   = REQ_DATA[i*DW +: DW];
            end
        end
    end

    // Round-robin pick: first valid requester searching from ptr+1 with wrap
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && REQ_VALID[w_idx]) begin
                w_found = 1'b1;
                w_pick  = NREQ'(1) << w_idx;
            end
        end
    end

    assign w_xfer = (r_state == c_S_XFER) && w_valid_g && TX_RDY;

    // Next-state logic for grant, pointer, stall counter and abort pulse
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_scnt_nxt  = r_scnt;
        w_abort_nxt = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_scnt_nxt = '0;
                if (w_found) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = c_S_XFER;
                end
            end
            c_S_XFER: begin
                if (w_xfer) begin
                    w_scnt_nxt = '0;
                    if (w_last_g) begin
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = w_hold_idx;
                        w_state_nxt = c_S_IDLE;
                    end
                end else if (!w_valid_g) begin
                    if (r_scnt == c_CW'(IDLE_MAX - 1)) begin
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = w_hold_idx;
                        w_scnt_nxt  = '0;
                        w_abort_nxt = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_scnt_nxt = r_scnt + c_CW'(1);
                    end
                end
                // valid high but TX_RDY low: counter holds
            end
            default: begin
                w_gnt_nxt   = '0;
                w_scnt_nxt  = '0;
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; ptr resets so requester 0 wins first
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_S_IDLE;
            r_gnt   <= '0;
            r_ptr   <= c_PW'(NREQ - 1);
            r_scnt  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_scnt  <= w_scnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign REQ_READY = (r_state == c_S_XFER) ? (r_gnt & {NREQ{TX_RDY}}) : '0;
    assign GNT       = r_gnt;
    assign TX_WEN    = w_xfer;
    assign TX_DIN    = w_data_g;
    assign BUSY      = (r_state == c_S_XFER);
    assign ABORT     = r_abort;

endmodule
`default_nettype wire
